alu_seq16: RTL

ALU_SEQ16 -- requirements
Module: alu_seq16

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu8_slice.sv | 44 ++++
 rtl/alu_seq16.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the byte-serial 16-bit ALU sequencer.
//   - FUNC_* : operation codes carried on in_func
//   - stateT : sequencer FSM states (IDLE -> LO -> HI -> DONE)
//   - isLegalFunc : tells whether a func code is implemented in this build
// Configuration macro: ALU_SEQ_SUB_EN
//   When defined, FUNC_SUB is a legal operation.
//   When undefined, FUNC_SUB is treated like any other unused code.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_AND = 3'b001;
    localparam logic [2:0] FUNC_OR  = 3'b010;
    localparam logic [2:0] FUNC_SUB = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10,
        DONE = 2'b11
    } stateT;

    function automatic logic isLegalFunc(input logic [2:0] func);
        logic legal;
        legal = 1'b0;
        case (func)
            FUNC_ADD, FUNC_AND, FUNC_OR: legal = 1'b1;
`ifdef ALU_SEQ_SUB_EN
            FUNC_SUB: legal = 1'b1;
`else
            FUNC_SUB: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu8_slice.sv
// -----------------------------------------------------------------------------
// alu8_slice
// Purely combinational 8-bit ALU slice shared by both byte passes.
// Ports:
//   a, b      : 8-bit operand bytes
//   carryIn   : carry into bit 0 (used by ADD only)
//   func      : FUNC_ADD / FUNC_AND / FUNC_OR; any other code yields 0
//   result    : 8-bit result byte
//   carryOut  : carry out of bit 7 (0 for the logical operations)
// Subtraction is built by the caller (inverted b, carry-in of 1).
// -----------------------------------------------------------------------------
module alu8_slice
    import alu_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carryIn,
    input  logic [2:0] func,
    output logic [7:0] result,
    output logic       carryOut
);

    logic [8:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {8'd0, carryIn};

    always_comb begin
        result   = 8'd0;
        carryOut = 1'b0;
        case (func)
            FUNC_ADD: begin
                result   = sum[7:0];
                carryOut = sum[8];
            end
            FUNC_AND: result = a & b;
            FUNC_OR:  result = a | b;
            default: begin
                result   = 8'd0;
                carryOut = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq16.sv
// -----------------------------------------------------------------------------
// alu_seq16
// 16-bit ALU evaluated as two 8-bit passes through one shared alu8_slice.
// A request is taken in IDLE, the low byte is computed in LO, the high byte
// in HI, and the result is presented in DONE until the consumer accepts it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake (ready only in IDLE)
//   in_a, in_b            : 16-bit operands
//   in_carry              : carry-in for ADD
//   in_func               : FUNC_* operation code
//   out_valid / out_ready : result handshake (valid only in DONE)
//   out_result            : 16-bit result
//   out_carry, out_zero, out_neg, out_err : flags
// Configuration macro: ALU_SEQ_SUB_EN enables func 011 (SUB = a + ~b + 1).
// -----------------------------------------------------------------------------
module alu_seq16
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_carry,
    input  logic [2:0]  in_func,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_carry,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_err
);

    stateT       state;
    stateT       nextState;

    logic [15:0] opA;
    logic [15:0] opB;
    logic        opCarry;
    logic [2:0]  opFunc;
    logic [7:0]  resLo;
    logic        carryLo;

    logic [7:0]  sliceA;
    logic [7:0]  sliceB;
    logic        sliceCin;
    logic [2:0]  sliceFunc;
    logic [7:0]  sliceRes;
    logic        sliceCout;
    logic        isSub;
    logic        legal;
    logic [15:0] fullRes;

    assign legal   = isLegalFunc(opFunc);
    assign fullRes = {sliceRes, resLo};

`ifdef ALU_SEQ_SUB_EN
    assign isSub = (opFunc == FUNC_SUB);
`else
    assign isSub = 1'b0;
`endif

    // Handshake outputs come straight from the state so reset takes effect
    // without waiting for a clock edge.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Byte select and operand conditioning for the shared slice. SUB runs
    // through the adder with b inverted; its carry-in of 1 applies only to
    // the low byte, the high byte always chains the stored low carry.
    always_comb begin
        sliceA    = (state == HI) ? opA[15:8] : opA[7:0];
        sliceB    = (state == HI) ? opB[15:8] : opB[7:0];
        sliceFunc = opFunc;
        sliceCin  = 1'b0;
        if (isSub) begin
            sliceB    = ~sliceB;
            sliceFunc = FUNC_ADD;
        end
        if (state == HI) begin
            sliceCin = carryLo;
        end else if (isSub) begin
            sliceCin = 1'b1;
        end else if (opFunc == FUNC_ADD) begin
            sliceCin = opCarry;
        end
    end

    alu8_slice uSlice (
        .a        (sliceA),
        .b        (sliceB),
        .carryIn  (sliceCin),
        .func     (sliceFunc),
        .result   (sliceRes),
        .carryOut (sliceCout)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (in_valid) nextState = LO;
            LO:   nextState = HI;
            HI:   nextState = DONE;
            DONE: if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opA        <= 16'd0;
            opB        <= 16'd0;
            opCarry    <= 1'b0;
            opFunc     <= FUNC_ADD;
            resLo      <= 8'd0;
            carryLo    <= 1'b0;
            out_result <= 16'd0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                // Request capture
                IDLE: begin
                    if (in_valid) begin
                        opA     <= in_a;
                        opB     <= in_b;
                        opCarry <= in_carry;
                        opFunc  <= in_func;
                    end
                end
                // Low byte pass
                LO: begin
                    resLo   <= sliceRes;
                    carryLo <= sliceCout;
                end
                // High byte pass; result and flags are registered here and
                // then held untouched until the next operation reaches HI.
                HI: begin
                    if (legal) begin
                        out_result <= fullRes;
                        out_carry  <= sliceCout;
                        out_zero   <= (fullRes == 16'd0);
                        out_neg    <= sliceRes[7];
                        out_err    <= 1'b0;
                    end else begin
                        out_result <= 16'd0;
                        out_carry  <= 1'b0;
                        out_zero   <= 1'b1;
                        out_neg    <= 1'b0;
                        out_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
